// File: rtl/rvfpm_pipeline_ctrl.sv
// rvfpm issue/pipeline-tracking stage: decodes RISC-V F instructions, blocks RAW hazards
// against in-flight FP destinations and shifts a valid/tag pipeline in step with enable.
module rvfpm_pipeline_ctrl #(
    parameter int PIPELINE_STAGES = 4,
    parameter int NUM_REGS        = 32
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        enable,
    input  logic        flush,
    input  logic        instr_valid,
    input  logic [31:0] instruction,
    output logic        instr_ready,
    output logic        retire_valid,
    output logic [4:0]  retire_rd,
    output logic        retire_to_fp,
    output logic        retire_to_int,
    output logic        retire_illegal,
    output logic [7:0]  retire_id,
    output logic [4:0]  occupancy
);

    localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OP_STORE_FP = 7'b0100111;
    localparam logic [6:0] OP_FMADD    = 7'b1000011;
    localparam logic [6:0] OP_FMSUB    = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB   = 7'b1001011;
    localparam logic [6:0] OP_FNMADD   = 7'b1001111;
    localparam logic [6:0] OP_OP_FP    = 7'b1010011;

    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0000100;
    localparam logic [6:0] F7_MUL    = 7'b0001000;
    localparam logic [6:0] F7_DIV    = 7'b0001100;
    localparam logic [6:0] F7_SQRT   = 7'b0101100;
    localparam logic [6:0] F7_SGNJ   = 7'b0010000;
    localparam logic [6:0] F7_MINMAX = 7'b0010100;
    localparam logic [6:0] F7_CVT_W  = 7'b1100000;
    localparam logic [6:0] F7_MV_X   = 7'b1110000;
    localparam logic [6:0] F7_CMP    = 7'b1010000;
    localparam logic [6:0] F7_CVT_SW = 7'b1101000;
    localparam logic [6:0] F7_MV_W_X = 7'b1111000;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       to_fp;
        logic       to_int;
        logic       illegal;
        logic [7:0] id;
    } entry_t;

    entry_t         stage_r [PIPELINE_STAGES];
    logic [7:0]     tag_r;
    logic [4:0]     occ_r;

    logic [6:0]     opcode_s;
    logic [6:0]     funct7_s;
    logic [4:0]     rs1_s;
    logic [4:0]     rs2_s;
    logic [4:0]     rs3_s;
    logic           dec_to_fp_s;
    logic           dec_to_int_s;
    logic           dec_illegal_s;
    logic           use_rs1_s;
    logic           use_rs2_s;
    logic           use_rs3_s;
    logic [4:0]     dec_rd_s;
    logic [NUM_REGS-1:0] busy_s;
    logic           hazard_s;
    logic           accept_s;
    entry_t         new_entry_s;
    logic [4:0]     occ_next_s;
    logic           unused_rm;

    assign opcode_s  = instruction[6:0];
    assign funct7_s  = instruction[31:25];
    assign rs1_s     = instruction[19:15];
    assign rs2_s     = instruction[24:20];
    assign rs3_s     = instruction[31:27];
    assign unused_rm = ^instruction[14:12];

    // Classify the presented word: destination file and which FP sources it reads
    always_comb begin
        dec_to_fp_s   = 1'b0;
        dec_to_int_s  = 1'b0;
        dec_illegal_s = 1'b0;
        use_rs1_s     = 1'b0;
        use_rs2_s     = 1'b0;
        use_rs3_s     = 1'b0;
        case (opcode_s)
            OP_LOAD_FP: begin
                dec_to_fp_s = 1'b1;
            end
            OP_STORE_FP: begin
                use_rs2_s = 1'b1;
            end
            OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
                dec_to_fp_s = 1'b1;
                use_rs1_s   = 1'b1;
                use_rs2_s   = 1'b1;
                use_rs3_s   = 1'b1;
            end
            OP_OP_FP: begin
                case (funct7_s)
                    F7_ADD, F7_SUB, F7_MUL, F7_DIV, F7_SGNJ, F7_MINMAX: begin
                        dec_to_fp_s = 1'b1;
                        use_rs1_s   = 1'b1;
                        use_rs2_s   = 1'b1;
                    end
                    F7_SQRT: begin
                        dec_to_fp_s = 1'b1;
                        use_rs1_s   = 1'b1;
                    end
                    F7_CVT_W, F7_MV_X: begin
                        dec_to_int_s = 1'b1;
                        use_rs1_s    = 1'b1;
                    end
                    F7_CMP: begin
                        dec_to_int_s = 1'b1;
                        use_rs1_s    = 1'b1;
                        use_rs2_s    = 1'b1;
                    end
                    F7_CVT_SW, F7_MV_W_X: begin
                        dec_to_fp_s = 1'b1;
                    end
                    default: begin
                        dec_illegal_s = 1'b1;
                    end
                endcase
            end
            default: begin
                dec_illegal_s = 1'b1;
            end
        endcase
    end

    // Entries without a destination carry rd 0 so retire_rd never shows a stray field
    assign dec_rd_s = (dec_to_fp_s || dec_to_int_s) ? instruction[11:7] : 5'd0;

    // Mask of FP registers with a pending write anywhere in the pipe, last stage included
    always_comb begin
        busy_s = '0;
        for (int i = 0; i < PIPELINE_STAGES; i++) begin
            busy_s[stage_r[i].rd] = busy_s[stage_r[i].rd] | (stage_r[i].valid & stage_r[i].to_fp);
        end
    end

    assign hazard_s = (use_rs1_s & busy_s[rs1_s]) |
                      (use_rs2_s & busy_s[rs2_s]) |
                      (use_rs3_s & busy_s[rs3_s]);

    assign instr_ready = !rst && enable && !flush && !hazard_s;
    assign accept_s    = instr_valid && instr_ready;

    // Entry loaded into stage 0 on an advance; a bubble is all-zero
    always_comb begin
        if (accept_s) begin
            new_entry_s = '{valid: 1'b1, rd: dec_rd_s, to_fp: dec_to_fp_s,
                            to_int: dec_to_int_s, illegal: dec_illegal_s, id: tag_r};
        end else begin
            new_entry_s = '0;
        end
    end

    // Occupancy after an advance: everything but the retiring stage plus the new entry
    always_comb begin
        occ_next_s = {4'd0, accept_s};
        for (int i = 0; i < PIPELINE_STAGES - 1; i++) begin
            occ_next_s = occ_next_s + {4'd0, stage_r[i].valid};
        end
    end

    // Pipeline, tag counter and occupancy state
    always_ff @(posedge ck) begin
        if (rst) begin
            for (int i = 0; i < PIPELINE_STAGES; i++) begin
                stage_r[i] <= '0;
            end
            tag_r <= 8'd0;
            occ_r <= 5'd0;
        end else if (flush) begin
            for (int i = 0; i < PIPELINE_STAGES; i++) begin
                stage_r[i] <= '0;
            end
            occ_r <= 5'd0;
        end else if (enable) begin
            for (int i = PIPELINE_STAGES - 1; i > 0; i--) begin
                stage_r[i] <= stage_r[i-1];
            end
            stage_r[0] <= new_entry_s;
            tag_r      <= tag_r + {7'd0, accept_s};
            occ_r      <= occ_next_s;
        end
    end

    assign retire_valid   = stage_r[PIPELINE_STAGES-1].valid;
    assign retire_rd      = stage_r[PIPELINE_STAGES-1].rd;
    assign retire_to_fp   = stage_r[PIPELINE_STAGES-1].to_fp;
    assign retire_to_int  = stage_r[PIPELINE_STAGES-1].to_int;
    assign retire_illegal = stage_r[PIPELINE_STAGES-1].illegal;
    assign retire_id      = stage_r[PIPELINE_STAGES-1].id;
    assign occupancy      = occ_r;

endmodule
